// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file with a load-use busy scoreboard.
//
// Storage: 2**ADDR_W registers of DATA_W bits, cleared by reset.
// Two write ports:
//   port A (wa_*): ALU writeback.
//   port B (wb_*): load / multi-cycle writeback. It wins an address
//                  conflict with port A and clears the busy bit.
// Two combinational read ports (ra_*, rb_*) with write-through bypass.
// Port B has priority over port A, and port A over the stored value.
// Scoreboard: iss_en/iss_addr marks a register pending, and a port-B
// write clears it. A same-cycle issue wins over a clear.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   wa_en, wa_addr, wa_data   write port A
//   wb_en, wb_addr, wb_data   write port B (also clears busy)
//   ra_addr -> ra_data, ra_busy   read port 1
//   rb_addr -> rb_data, rb_busy   read port 2
//   iss_en, iss_addr          mark a register busy
//   busy_vec                  registered busy bits, bit i = register i
//   busy_cnt                  registered population count of busy_vec
//
// Build option:
//   REGFILE_MP_ZERO_REG_EN    register 0 is hard-wired to zero. Writes
//                             and issues to address 0 are dropped.

module regfile_mp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [ADDR_W-1:0]        ra_addr,
    output logic [DATA_W-1:0]        ra_data,
    output logic                     ra_busy,
    input  logic [ADDR_W-1:0]        rb_addr,
    output logic [DATA_W-1:0]        rb_data,
    output logic                     rb_busy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [(2**ADDR_W)-1:0]   busy_vec,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

`ifdef REGFILE_MP_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    logic             wa_we;
    logic             wb_we;
    logic             iss_set;
    logic [DEPTH-1:0] busy_nxt;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [ADDR_W:0]  cnt_nxt;

    // Effective enables. Register 0 never stores data and never becomes
    // busy when it is hard-wired. Gating the bypass with these enables
    // also keeps register 0 reading as zero on the bypass path.
    always_comb begin
        wa_we   = wa_en;
        wb_we   = wb_en;
        iss_set = iss_en;
        if (ZERO_REG) begin
            if (wa_addr == '0)  wa_we   = 1'b0;
            if (wb_addr == '0)  wb_we   = 1'b0;
            if (iss_addr == '0) iss_set = 1'b0;
        end
    end

    // Read ports. The later assignment has higher priority (B > A > stored).
    always_comb begin
        ra_data = mem[ra_addr];
        if (wa_we && (wa_addr == ra_addr)) ra_data = wa_data;
        if (wb_we && (wb_addr == ra_addr)) ra_data = wb_data;
    end

    always_comb begin
        rb_data = mem[rb_addr];
        if (wa_we && (wa_addr == rb_addr)) rb_data = wa_data;
        if (wb_we && (wb_addr == rb_addr)) rb_data = wb_data;
    end

    // A clearing writeback is seen by the reader in the same cycle.
    // A new issue only becomes visible once busy_vec is updated.
    assign ra_busy = busy_vec[ra_addr] & ~(wb_en & (wb_addr == ra_addr));
    assign rb_busy = busy_vec[rb_addr] & ~(wb_en & (wb_addr == rb_addr));

    // Scoreboard next state. The issue is applied after the clear, so an
    // issue and a clear of the same register leave it busy.
    always_comb begin
        busy_nxt = busy_vec;
        if (wb_en)   busy_nxt[wb_addr]  = 1'b0;
        if (iss_set) busy_nxt[iss_addr] = 1'b1;
    end

    // busy_cnt moves by at most one each way per cycle. It counts only
    // real 0->1 and 1->0 transitions, so it always matches popcount(busy_vec).
    always_comb begin
        cnt_inc = iss_set & ~busy_vec[iss_addr];
        cnt_dec = wb_en & busy_vec[wb_addr] & ~(iss_set & (iss_addr == wb_addr));
        cnt_nxt = busy_cnt;
        if (cnt_inc && !cnt_dec)      cnt_nxt = busy_cnt + CNT_ONE;
        else if (cnt_dec && !cnt_inc) cnt_nxt = busy_cnt - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy_vec <= '0;
            busy_cnt <= '0;
        end else begin
            if (wa_we && !(wb_we && (wa_addr == wb_addr))) begin
                mem[wa_addr] <= wa_data;
            end
            if (wb_we) begin
                mem[wb_addr] <= wb_data;
            end
            busy_vec <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 8;

`ifdef REGFILE_MP_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic          clk = 1'b1;
    logic          rst;
    logic          wa_en, wb_en, iss_en;
    logic [AW-1:0] wa_addr, wb_addr, ra_addr, rb_addr, iss_addr;
    logic [DW-1:0] wa_data, wb_data;
    logic [DW-1:0] ra_data, rb_data;
    logic          ra_busy, rb_busy;
    logic [N-1:0]  busy_vec;
    logic [AW:0]   busy_cnt;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ra_addr(ra_addr), .ra_data(ra_data), .ra_busy(ra_busy),
        .rb_addr(rb_addr), .rb_data(rb_data), .rb_busy(rb_busy),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_vec(busy_vec), .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic [DW-1:0] ra_data;
        logic [DW-1:0] rb_data;
        logic          ra_busy;
        logic          rb_busy;
        logic [N-1:0]  busy_vec;
        logic [AW:0]   busy_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: architectural register contents and pending flags.
    logic [DW-1:0] m_mem  [N];
    bit            m_busy [N];

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (ZERO && a == '0)          return '0;
        if (wb_en && wb_addr == a)    return wb_data;
        if (wa_en && wa_addr == a)    return wa_data;
        return m_mem[a];
    endfunction

    function automatic logic m_rbusy(input logic [AW-1:0] a);
        return m_busy[a] && !(wb_en && wb_addr == a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (wa_en && !(ZERO && wa_addr == '0)) m_mem[wa_addr] = wa_data;
        if (wb_en && !(ZERO && wb_addr == '0)) m_mem[wb_addr] = wb_data;
        if (wb_en) m_busy[wb_addr] = 1'b0;
        if (iss_en && !(ZERO && iss_addr == '0)) m_busy[iss_addr] = 1'b1;
    endtask

    // Called just after a rising edge, with the inputs already driven. The
    // expectations are queued here and checked at the falling edge. The model
    // then advances at the next rising edge.
    task automatic cycle();
        exp_t e;
        int   cnt;
        if (rst) model_reset();
        e.ra_data = m_read(ra_addr);
        e.rb_data = m_read(rb_addr);
        e.ra_busy = m_rbusy(ra_addr);
        e.rb_busy = m_rbusy(rb_addr);
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            e.busy_vec[i] = m_busy[i];
            cnt += int'(m_busy[i]);
        end
        e.busy_cnt = cnt[AW:0];
        exp_q.push_back(e);
        @(posedge clk);
        if (!rst) model_update();
        #1;
    endtask

    task automatic idle();
        rst      = 1'b0;
        wa_en    = 1'b0;
        wb_en    = 1'b0;
        iss_en   = 1'b0;
        wa_addr  = '0;
        wb_addr  = '0;
        iss_addr = '0;
        wa_data  = '0;
        wb_data  = '0;
        ra_addr  = AW'($urandom_range(0, N-1));
        rb_addr  = AW'($urandom_range(0, N-1));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, expv);
        end
    endtask

    // Monitor: at each falling edge, pops and compares one queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ra_data",  32'(ra_data),  32'(e.ra_data));
            chk("rb_data",  32'(rb_data),  32'(e.rb_data));
            chk("ra_busy",  32'(ra_busy),  32'(e.ra_busy));
            chk("rb_busy",  32'(rb_busy),  32'(e.rb_busy));
            chk("busy_vec", 32'(busy_vec), 32'(e.busy_vec));
            chk("busy_cnt", 32'(busy_cnt), 32'(e.busy_cnt));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle(); rst = 1'b1; cycle();
        idle(); cycle();

        // Reset mid-cycle after a write and an issue.
        idle(); wa_en = 1'b1; wa_addr = 3'd3; wa_data = 16'h1234; cycle();
        idle(); ra_addr = 3'd3; iss_en = 1'b1; iss_addr = 3'd1; cycle();
        idle(); ra_addr = 3'd3; rst = 1'b1; cycle();
        idle(); ra_addr = 3'd3; cycle();

        // Port conflict: port B wins, both in the bypass and in storage.
        idle(); wa_en = 1'b1; wa_addr = 3'd5; wa_data = 16'hAAAA;
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h5555; ra_addr = 3'd5; cycle();
        idle(); ra_addr = 3'd5; cycle();

        // Port A bypass.
        idle(); wa_en = 1'b1; wa_addr = 3'd2; wa_data = 16'h00FF; rb_addr = 3'd2; cycle();
        idle(); rb_addr = 3'd2; cycle();

        // Issue, then a clearing writeback.
        idle(); iss_en = 1'b1; iss_addr = 3'd4; ra_addr = 3'd4; cycle();
        idle(); ra_addr = 3'd4; cycle();
        idle(); wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h0042; ra_addr = 3'd4; cycle();
        idle(); ra_addr = 3'd4; cycle();

        // Issue and clear of the same busy register in one cycle.
        idle(); iss_en = 1'b1; iss_addr = 3'd6; cycle();
        idle(); iss_en = 1'b1; iss_addr = 3'd6; wb_en = 1'b1; wb_addr = 3'd6;
        wb_data = 16'h0606; ra_addr = 3'd6; cycle();
        idle(); ra_addr = 3'd6; rb_addr = 3'd6; cycle();

        // Fill the scoreboard, including re-issues of registers already busy.
        for (int i = 0; i < N; i++) begin
            idle(); iss_en = 1'b1; iss_addr = AW'(i); cycle();
        end
        idle(); iss_en = 1'b1; iss_addr = 3'd7; cycle();
        idle(); cycle();

        // Register 0 write and issue.
        idle(); rst = 1'b1; cycle();
        idle(); wa_en = 1'b1; wa_addr = 3'd0; wa_data = 16'hBEEF;
        iss_en = 1'b1; iss_addr = 3'd0; ra_addr = 3'd0; cycle();
        idle(); ra_addr = 3'd0; rb_addr = 3'd0; cycle();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            idle();
            rst      = ($urandom_range(0, 59) == 0);
            wa_en    = 1'($urandom_range(0, 1));
            wa_addr  = AW'($urandom_range(0, N-1));
            wa_data  = DW'($urandom);
            wb_en    = ($urandom_range(0, 2) == 0);
            wb_addr  = AW'($urandom_range(0, N-1));
            wb_data  = DW'($urandom);
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = AW'($urandom_range(0, N-1));
            if ($urandom_range(0, 3) == 0) ra_addr = wb_addr;
            if ($urandom_range(0, 3) == 0) rb_addr = wa_addr;
            cycle();
        end

        idle();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d expected=0 pending entries", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the 8x16 single-write register file.
- Two write ports: port A is ALU writeback; port B is load/multi-cycle writeback, and it wins on address conflict.
- Two combinational read ports with write-through bypass.
- Busy scoreboard: the issue stage marks a destination pending, and a port-B writeback clears it. The decode stage uses the busy flags for load-use stalls.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register address width. Depth is 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wa_en  in  1  port A write enable.
- wa_addr  in  ADDR_W  port A destination.
- wa_data  in  DATA_W  port A write data.
- wb_en  in  1  port B write enable; also clears busy.
- wb_addr  in  ADDR_W  port B destination.
- wb_data  in  DATA_W  port B write data.
- ra_addr  in  ADDR_W  read port 1 address.
- ra_data  out  DATA_W  read port 1 data.
- ra_busy  out  1  read port 1 register pending.
- rb_addr  in  ADDR_W  read port 2 address.
- rb_data  out  DATA_W  read port 2 data.
- rb_busy  out  1  read port 2 register pending.
- iss_en  in  1  mark iss_addr busy.
- iss_addr  in  ADDR_W  register to mark busy.
- busy_vec  out  2**ADDR_W  registered busy bits, bit i = register i.
- busy_cnt  out  ADDR_W+1  registered population count of busy_vec.

Behaviour:
- Reset (asynchronous, rst=1):
  - All registers are cleared to 0.
  - busy_vec=0 and busy_cnt=0.
  - Read data outputs show 0, or bypassed write data if a write enable is high.
  - Reset asserted mid-operation discards pending writes and issues immediately; there is no partial state.
- Write, on rising edge with rst=0:
  - wa_en writes wa_data to wa_addr.
  - wb_en writes wb_data to wb_addr.
  - If both enables are high and wa_addr==wb_addr, only wb_data is stored.
- Read (combinational, zero latency). Priority for data on each port:
  - first, wb_data if wb_en and wb_addr matches;
  - else wa_data if wa_en and wa_addr matches;
  - else the stored value.
- Scoreboard, per register i, next state:
  - busy[i] is set if iss_en and iss_addr==i;
  - else cleared if wb_en and wb_addr==i;
  - else held.
  - A same-cycle issue and clear of the same register leaves it busy: the new issue wins.
  - Port A writes never affect busy.
  - Issuing an already-busy register leaves it busy; the count does not change.
  - A port-B write to a non-busy register is a legal plain write.
- Read busy flags:
  - ra_busy = busy[ra_addr] AND NOT (wb_en AND wb_addr==ra_addr). This means a clearing writeback is bypassed to the reader in the same cycle.
  - A same-cycle issue does not raise ra_busy until the next cycle.
  - rb_busy follows the same rule.
- busy_cnt:
  - Registered; equals the popcount of busy_vec at all times.
  - Updated by +1, -1 or 0 per cycle, consistent with the set/clear rules above.
  - Range 0..2**ADDR_W; it never wraps, because a full count requires every register to be busy.
- Reads and writes must not produce X outputs for any in-range address. All addresses are in range by construction.

Optional Feature:
- Macro: REGFILE_MP_ZERO_REG_EN.
- Defined:
  - Register 0 reads as 0 on both ports, including the bypass path.
  - Writes to address 0 from either port are discarded.
  - iss_en to address 0 is ignored, so busy[0] stays 0 and ra_busy/rb_busy for address 0 stay 0.
  - busy_cnt never counts register 0.
- Undefined: register 0 is an ordinary register, identical to all others.

Test Plan:
- Reset: assert rst mid-cycle after writing 0x1234 to r3 -> ra_data(r3)=0 immediately, busy_vec=0, busy_cnt=0.
- Port conflict and bypass:
  - Same cycle, wa_en r5=0xAAAA and wb_en r5=0x5555, with ra_addr=5 -> ra_data=0x5555 in that cycle.
  - Next cycle, with no writes -> ra_data=0x5555.
- Port A bypass: wa_en r2=0x00FF, rb_addr=2 -> rb_data=0x00FF the same cycle; r2 holds 0x00FF afterwards.
- Scoreboard:
  - iss r4 -> next cycle ra_busy(r4)=1, busy_cnt=1.
  - wb_en r4=0x0042 -> that cycle ra_busy=0 and ra_data=0x0042; next cycle busy_cnt=0.
- Simultaneous events:
  - Starting with r6 busy, iss r6 and wb r6 in the same cycle -> r6 remains busy, busy_cnt unchanged.
  - Issue all 8 registers -> busy_cnt=8, busy_vec=0xFF.
- Zero register: with REGFILE_MP_ZERO_REG_EN, wa_en r0=0xBEEF and iss r0 -> ra_data(r0)=0, busy_vec[0]=0. Without the macro -> ra_data(r0)=0xBEEF.
